// File: rtl/ex_div_pkg.sv
// Shared types and encodings for the EX-stage multi-cycle divider.
// Optional early-out path is selected with the DIV_EARLY_OUT_EN macro.
package ex_div_pkg;

    localparam int DIV_DATA_W = 32;

    typedef enum logic [1:0] {
        DIV_FREE   = 2'b00,
        DIV_BYZERO = 2'b01,
        DIV_ON     = 2'b10,
        DIV_END    = 2'b11
    } div_state_e;

    localparam logic DIV_RESULT_READY     = 1'b1;
    localparam logic DIV_RESULT_NOT_READY = 1'b0;
    localparam logic DIV_START            = 1'b1;
    localparam logic DIV_STOP             = 1'b0;
    localparam logic DIV_ANNUL            = 1'b1;

endpackage

// File: rtl/ex_div_step.sv
// One combinational restoring-division step: shift {rem,quo} left, subtract
// the divisor when it fits and record the quotient bit.
module ex_div_step
    import ex_div_pkg::*;
#(
    parameter int DATA_W = DIV_DATA_W
) (
    input  logic [DATA_W-1:0] rem_i,
    input  logic [DATA_W-1:0] quo_i,
    input  logic [DATA_W-1:0] divisor_i,
    output logic [DATA_W-1:0] rem_o,
    output logic [DATA_W-1:0] quo_o
);

    logic [DATA_W:0] rem_ext_s;
    logic [DATA_W:0] diff_s;

    // The shifted remainder can reach 2*divisor-1, so it needs one extra bit;
    // the sign of the widened difference tells whether the divisor fits.
    always_comb begin
        rem_ext_s = {rem_i, quo_i[DATA_W-1]};
        diff_s    = rem_ext_s - {1'b0, divisor_i};
        if (diff_s[DATA_W] == 1'b0) begin
            rem_o = diff_s[DATA_W-1:0];
            quo_o = {quo_i[DATA_W-2:0], 1'b1};
        end else begin
            rem_o = rem_ext_s[DATA_W-1:0];
            quo_o = {quo_i[DATA_W-2:0], 1'b0};
        end
    end

endmodule

// File: rtl/ex_div.sv
// Multi-cycle restoring divider (DIV/DIVU) for the EX stage.
// Define DIV_EARLY_OUT_EN to finish in one cycle when |dividend| < |divisor|.
module ex_div
    import ex_div_pkg::*;
#(
    parameter int DATA_W = DIV_DATA_W
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  signed_div_i,
    input  logic [DATA_W-1:0]     opdata1_i,
    input  logic [DATA_W-1:0]     opdata2_i,
    input  logic                  start_i,
    input  logic                  annul_i,
    output logic [2*DATA_W-1:0]   result_o,
    output logic                  ready_o
);

    localparam int CNT_W = $clog2(DATA_W) + 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DATA_W);

    function automatic logic [DATA_W-1:0] cond_neg(input logic [DATA_W-1:0] x,
                                                   input logic neg);
        return neg ? (~x + DATA_W'(1)) : x;
    endfunction

    div_state_e           state_q, state_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic [DATA_W-1:0]    rem_q, rem_d;
    logic [DATA_W-1:0]    quo_q, quo_d;
    logic [DATA_W-1:0]    divisor_q, divisor_d;
    logic                 neg_quo_q, neg_quo_d;
    logic                 neg_rem_q, neg_rem_d;
    logic [2*DATA_W-1:0]  result_q, result_d;
    logic                 ready_q, ready_d;

    logic                 a_neg_s, b_neg_s;
    logic [DATA_W-1:0]    a_mag_s, b_mag_s;
    logic [DATA_W-1:0]    step_rem_s, step_quo_s;

    assign a_neg_s = signed_div_i & opdata1_i[DATA_W-1];
    assign b_neg_s = signed_div_i & opdata2_i[DATA_W-1];
    assign a_mag_s = cond_neg(opdata1_i, a_neg_s);
    assign b_mag_s = cond_neg(opdata2_i, b_neg_s);

    ex_div_step #(.DATA_W(DATA_W)) u_step (
        .rem_i     (rem_q),
        .quo_i     (quo_q),
        .divisor_i (divisor_q),
        .rem_o     (step_rem_s),
        .quo_o     (step_quo_s)
    );

    // Next-state, datapath and output computation; annul overrides every state.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        rem_d     = rem_q;
        quo_d     = quo_q;
        divisor_d = divisor_q;
        neg_quo_d = neg_quo_q;
        neg_rem_d = neg_rem_q;
        result_d  = result_q;
        ready_d   = ready_q;

        if (annul_i == DIV_ANNUL) begin
            state_d  = DIV_FREE;
            result_d = '0;
            ready_d  = DIV_RESULT_NOT_READY;
        end else begin
            case (state_q)
                DIV_FREE: begin
                    result_d = '0;
                    ready_d  = DIV_RESULT_NOT_READY;
                    if (start_i == DIV_START) begin
                        divisor_d = b_mag_s;
                        neg_quo_d = a_neg_s ^ b_neg_s;
                        neg_rem_d = a_neg_s;
                        cnt_d     = '0;
                        // BYZERO simply publishes {rem_q, quo_q} one edge later.
                        if (opdata2_i == '0) begin
                            state_d = DIV_BYZERO;
                            rem_d   = '0;
                            quo_d   = '0;
                        end
`ifdef DIV_EARLY_OUT_EN
                        else if (a_mag_s < b_mag_s) begin
                            state_d = DIV_BYZERO;
                            rem_d   = opdata1_i;
                            quo_d   = '0;
                        end
`endif
                        else begin
                            state_d = DIV_ON;
                            rem_d   = '0;
                            quo_d   = a_mag_s;
                        end
                    end else begin
                        state_d = DIV_FREE;
                    end
                end
                DIV_BYZERO: begin
                    state_d  = DIV_END;
                    result_d = {rem_q, quo_q};
                    ready_d  = DIV_RESULT_READY;
                end
                DIV_ON: begin
                    if (cnt_q == CNT_LAST) begin
                        state_d  = DIV_END;
                        result_d = {cond_neg(rem_q, neg_rem_q), cond_neg(quo_q, neg_quo_q)};
                        ready_d  = DIV_RESULT_READY;
                    end else begin
                        rem_d = step_rem_s;
                        quo_d = step_quo_s;
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
                DIV_END: begin
                    if (start_i == DIV_STOP) begin
                        state_d  = DIV_FREE;
                        result_d = '0;
                        ready_d  = DIV_RESULT_NOT_READY;
                    end else begin
                        state_d = DIV_END;
                    end
                end
                default: begin
                    state_d  = DIV_FREE;
                    result_d = '0;
                    ready_d  = DIV_RESULT_NOT_READY;
                end
            endcase
        end
    end

    // State and datapath registers with asynchronous reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= DIV_FREE;
            cnt_q     <= '0;
            rem_q     <= '0;
            quo_q     <= '0;
            divisor_q <= '0;
            neg_quo_q <= 1'b0;
            neg_rem_q <= 1'b0;
            result_q  <= '0;
            ready_q   <= DIV_RESULT_NOT_READY;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            rem_q     <= rem_d;
            quo_q     <= quo_d;
            divisor_q <= divisor_d;
            neg_quo_q <= neg_quo_d;
            neg_rem_q <= neg_rem_d;
            result_q  <= result_d;
            ready_q   <= ready_d;
        end
    end

    assign result_o = result_q;
    assign ready_o  = ready_q;

endmodule

// File: tb/tb_ex_div.sv
// Directed self-checking bench for ex_div (default or DIV_EARLY_OUT_EN build).
module tb_ex_div;

    logic        clk;
    logic        rst;
    logic        signed_div;
    logic [31:0] op1;
    logic [31:0] op2;
    logic        start;
    logic        annul;
    logic [63:0] result;
    logic        ready;

    int passed = 0;
    int failed = 0;
    int total  = 0;

`ifdef DIV_EARLY_OUT_EN
    localparam int EO_LAT = 2;
`else
    localparam int EO_LAT = 34;
`endif

    ex_div dut (
        .clk          (clk),
        .rst          (rst),
        .signed_div_i (signed_div),
        .opdata1_i    (op1),
        .opdata2_i    (op2),
        .start_i      (start),
        .annul_i      (annul),
        .result_o     (result),
        .ready_o      (ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) passed++;
        else begin
            failed++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Runs one division; lat counts edges from E0 up to the one after which ready is seen.
    task automatic do_div(input logic s, input logic [31:0] a, input logic [31:0] b,
                          input logic [63:0] exp, input int lat, input string tag);
        int n;
        signed_div = s;
        op1 = a;
        op2 = b;
        start = 1'b1;
        tick();
        n = 1;
        op1 = 32'hDEAD_BEEF;
        op2 = 32'h0000_0000;
        signed_div = ~s;
        while (ready !== 1'b1 && n < 40) begin
            tick();
            n++;
        end
        chk({tag, " latency"}, 64'(n), 64'(lat));
        chk({tag, " result"}, result, exp);
        tick();
        chk({tag, " hold ready"}, {63'd0, ready}, 64'd1);
        chk({tag, " hold result"}, result, exp);
        start = 1'b0;
        tick();
        chk({tag, " drop ready"}, {63'd0, ready}, 64'd0);
        chk({tag, " drop result"}, result, 64'd0);
    endtask

    initial begin
        int n;
        rst = 1'b1;
        start = 1'b0;
        annul = 1'b0;
        signed_div = 1'b0;
        op1 = 32'd0;
        op2 = 32'd0;
        tick();
        tick();
        chk("reset ready", {63'd0, ready}, 64'd0);
        chk("reset result", result, 64'd0);
        rst = 1'b0;
        tick();

        do_div(1'b0, 32'd100, 32'd7, 64'h00000002_0000000E, 34, "divu 100/7");
        do_div(1'b1, 32'hFFFF_FFF9, 32'd2, 64'hFFFFFFFF_FFFFFFFD, 34, "div -7/2");
        do_div(1'b1, 32'd7, 32'hFFFF_FFFE, 64'h00000001_FFFFFFFD, 34, "div 7/-2");
        do_div(1'b0, 32'd5, 32'd0, 64'd0, 2, "divu by zero");
        do_div(1'b1, 32'hFFFF_FFFB, 32'd0, 64'd0, 2, "div by zero");
        do_div(1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 64'h00000000_80000000, 34, "div overflow");
        do_div(1'b0, 32'hFFFF_FFFF, 32'h8000_0000, 64'h7FFFFFFF_00000001, 34, "divu big divisor");

        // Annul after ten iterations; a new start follows right away.
        signed_div = 1'b0;
        op1 = 32'd1000;
        op2 = 32'd3;
        start = 1'b1;
        tick();
        repeat (10) tick();
        annul = 1'b1;
        start = 1'b0;
        tick();
        chk("annul ready", {63'd0, ready}, 64'd0);
        chk("annul result", result, 64'd0);
        annul = 1'b0;
        do_div(1'b0, 32'd20, 32'd4, 64'h00000000_00000005, 34, "after annul 20/4");

        // Reset in the middle of an ON sequence.
        op1 = 32'd123;
        op2 = 32'd4;
        start = 1'b1;
        tick();
        repeat (6) tick();
        rst = 1'b1;
        #1;
        chk("rst mid-on ready", {63'd0, ready}, 64'd0);
        chk("rst mid-on result", result, 64'd0);
        rst = 1'b0;
        start = 1'b0;
        tick();
        do_div(1'b0, 32'd123, 32'd4, 64'h00000003_0000001E, 34, "after rst 123/4");

        // Asynchronous reset while a result is being held.
        op1 = 32'd9;
        op2 = 32'd3;
        start = 1'b1;
        n = 0;
        while (ready !== 1'b1 && n < 40) begin
            tick();
            n++;
        end
        chk("end-state result", result, 64'h00000000_00000003);
        #2;
        rst = 1'b1;
        #1;
        chk("async rst ready", {63'd0, ready}, 64'd0);
        chk("async rst result", result, 64'd0);
        rst = 1'b0;
        start = 1'b0;
        tick();

        do_div(1'b0, 32'd5, 32'd9, 64'h00000005_00000000, EO_LAT, "divu 5/9");
        do_div(1'b1, 32'hFFFF_FFFD, 32'd7, 64'hFFFFFFFD_00000000, EO_LAT, "div -3/7");

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
